// File: rtl/sys_mem_responder_if.sv
// System-bus bundle between the cache's system port (master) and the memory responder (slave).
interface sys_mem_responder_if;
  logic        sysstrobe;
  logic        sysrw;
  logic [15:0] sysaddress;
  logic [7:0]  sysdata_wr;
  logic [7:0]  sysdata_rd;
  logic        sysvalid;
  logic        sysdone;
  logic        sysbusy;

  modport master (
    output sysstrobe, sysrw, sysaddress, sysdata_wr,
    input  sysdata_rd, sysvalid, sysdone, sysbusy
  );

  modport slave (
    input  sysstrobe, sysrw, sysaddress, sysdata_wr,
    output sysdata_rd, sysvalid, sysdone, sysbusy
  );
endinterface

// File: rtl/sys_mem_responder.sv
// Byte-wide memory responder: strobe-decoded four-beat wrapping bursts against an internal
// byte array, with a fixed wait-state count modelling slow main memory.
module sys_mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input logic                clk,
  input logic                rst,
  sys_mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT       = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       LAST_BEAT = 2'd3;
  localparam logic [1:0]       PRE_LAST  = 2'd2;

  typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WWAIT} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        beat_q;
  logic [CNT_W-1:0]  wait_q;
  logic [7:0]        rdata_q;
  logic              valid_q;
  logic              done_q;
  logic              busy_q;

  logic [7:0] mem [DEPTH];

  // Beat address wraps inside the aligned 4-byte word; bit 2 never receives a carry.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [1:0]        k);
    return {base[ADDR_W-1:2], 2'(base[1:0] + k)};
  endfunction

  logic [ADDR_W-1:0] req_addr_c;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;

  assign req_addr_c = bus.sysaddress[ADDR_W-1:0];
  assign wr_en_c    = (state_q == WDATA);
  assign wr_addr_c  = beat_addr(addr_q, beat_q);

  // Array is deliberately not reset; an async reset forces IDLE so no write occurs under reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= bus.sysdata_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.sysstrobe) begin
            addr_q <= req_addr_c;
            beat_q <= '0;
            wait_q <= CNT_ONE;
            busy_q <= 1'b1;
            if (!bus.sysrw) begin
              state_q <= WDATA;
            end else if (LAT == '0) begin
              state_q <= RDATA;
              valid_q <= 1'b1;
              rdata_q <= mem[beat_addr(req_addr_c, 2'd0)];
            end else begin
              state_q <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (wait_q == LAT) begin
            state_q <= RDATA;
            valid_q <= 1'b1;
            rdata_q <= mem[beat_addr(addr_q, 2'd0)];
          end else begin
            wait_q <= wait_q + CNT_ONE;
          end
        end
        // Registered outputs are loaded one edge ahead, so sysdone rises on entry to beat 3.
        RDATA: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            beat_q  <= beat_q + 2'd1;
            rdata_q <= mem[beat_addr(addr_q, beat_q + 2'd1)];
            done_q  <= (beat_q == PRE_LAST);
          end
        end
        WDATA: begin
          if (beat_q == LAST_BEAT) begin
            if (LAT == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WWAIT;
              wait_q  <= CNT_ONE;
              done_q  <= (LAT == CNT_ONE);
            end
          end else begin
            beat_q <= beat_q + 2'd1;
            done_q <= (LAT == '0) && (beat_q == PRE_LAST);
          end
        end
        WWAIT: begin
          if (wait_q == LAT) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            wait_q <= wait_q + CNT_ONE;
            done_q <= ((wait_q + CNT_ONE) == LAT);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          rdata_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sysdata_rd = rdata_q;
  assign bus.sysvalid   = valid_q;
  assign bus.sysdone    = done_q;
  assign bus.sysbusy    = busy_q;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Bench for sys_mem_responder: one instance at latency 2, one at latency 0, checked against
// a cycle-timeline model of the bus protocol plus hand-computed literal burst values.
module tb_sys_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        stb   [2] = '{1'b0, 1'b0};
  logic        rw_s  [2] = '{1'b0, 1'b0};
  logic [15:0] ad    [2] = '{16'h0, 16'h0};
  logic [7:0]  wd    [2] = '{8'h0, 8'h0};
  logic [7:0]  o_rd  [2];
  logic        o_valid [2];
  logic        o_done  [2];
  logic        o_busy  [2];

  sys_mem_responder_if bus0 ();
  sys_mem_responder_if bus1 ();

  assign bus0.sysstrobe  = stb[0];
  assign bus0.sysrw      = rw_s[0];
  assign bus0.sysaddress = ad[0];
  assign bus0.sysdata_wr = wd[0];
  assign bus1.sysstrobe  = stb[1];
  assign bus1.sysrw      = rw_s[1];
  assign bus1.sysaddress = ad[1];
  assign bus1.sysdata_wr = wd[1];
  assign o_rd[0] = bus0.sysdata_rd;
  assign o_rd[1] = bus1.sysdata_rd;
  assign o_valid[0] = bus0.sysvalid;
  assign o_valid[1] = bus1.sysvalid;
  assign o_done[0] = bus0.sysdone;
  assign o_done[1] = bus1.sysdone;
  assign o_busy[0] = bus0.sysbusy;
  assign o_busy[1] = bus1.sysbusy;

  sys_mem_responder #(.ADDR_W(16), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sys_mem_responder #(.ADDR_W(16), .LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [15:0] ba(input logic [15:0] a, input int k);
    return (a & 16'hFFFC) | 16'((int'(a) + k) & 3);
  endfunction

  function automatic int key(input int i, input logic [15:0] a);
    return i * 65536 + int'(a);
  endfunction

  task automatic check(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Model: a request is a timeline of cycles 1..L+4 counted from the accepted strobe.
  logic        m_act [2] = '{1'b0, 1'b0};
  logic        m_rw  [2];
  logic [15:0] m_addr[2];
  int          m_cyc [2];
  logic [7:0]  mm [int];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act[0] = 1'b0;
      m_act[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (!m_rw[i] && m_cyc[i] >= 1 && m_cyc[i] <= 4)
            mm[key(i, ba(m_addr[i], m_cyc[i] - 1))] = wd[i];
          m_cyc[i]++;
          if (m_cyc[i] > lat_of(i) + 4) m_act[i] = 1'b0;
        end else if (stb[i]) begin
          m_act[i]  = 1'b1;
          m_cyc[i]  = 1;
          m_rw[i]   = rw_s[i];
          m_addr[i] = ad[i];
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int L;
    logic eb, ed, ev;
    logic [7:0] edat;
    int k;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        L  = lat_of(i);
        eb = m_act[i];
        ed = m_act[i] && (m_cyc[i] == L + 4);
        ev = m_act[i] && m_rw[i] && (m_cyc[i] >= L + 1) && (m_cyc[i] <= L + 4);
        edat = 8'h00;
        if (ev) begin
          k = key(i, ba(m_addr[i], m_cyc[i] - L - 1));
          if (mm.exists(k)) edat = mm[k];
        end
        check("model_busy",  i, 8'(o_busy[i]),  8'(eb));
        check("model_done",  i, 8'(o_done[i]),  8'(ed));
        check("model_valid", i, 8'(o_valid[i]), 8'(ev));
        check("model_rdata", i, o_rd[i], edat);
      end
    end
  end

  task automatic start(input int i, input logic r, input logic [15:0] a);
    @(negedge clk);
    stb[i]  = 1'b1;
    rw_s[i] = r;
    ad[i]   = a;
  endtask

  task automatic wait_done(input int i, input int exp_n);
    int n = 0;
    while (!o_done[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d: no sysdone within 40 cycles", i);
    end else begin
      check("done_cycle", i, 8'(n), 8'(exp_n));
    end
  endtask

  task automatic do_write(input int i, input logic [15:0] a, input logic [31:0] d);
    start(i, 1'b0, a);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stb[i] = 1'b0;
      wd[i]  = d[8*(3-k) +: 8];
      check("wbusy_lit", i, 8'(o_busy[i]), 8'h01);
    end
    wait_done(i, lat_of(i));
  endtask

  task automatic do_read(input int i, input logic [15:0] a, input logic [31:0] exp);
    int L;
    L = lat_of(i);
    start(i, 1'b1, a);
    for (int c = 1; c <= L + 4; c++) begin
      @(negedge clk);
      stb[i] = 1'b0;
      check("rbusy_lit", i, 8'(o_busy[i]), 8'h01);
      if (c > L) begin
        check("rdata_lit", i, o_rd[i], exp[8*(3-(c-L-1)) +: 8]);
        check("rvalid_lit", i, 8'(o_valid[i]), 8'h01);
      end else begin
        check("rvalid_lit", i, 8'(o_valid[i]), 8'h00);
      end
      check("rdone_lit", i, 8'(o_done[i]), (c == L + 4) ? 8'h01 : 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rd", i, o_rd[i], 8'h00);
      check("rst_valid", i, 8'(o_valid[i]), 8'h00);
      check("rst_done", i, 8'(o_done[i]), 8'h00);
      check("rst_busy", i, 8'(o_busy[i]), 8'h00);
    end
    rst = 1'b0;

    // Write, then plain and wrapped reads; the neighbouring word must stay untouched.
    do_write(0, 16'h1238, 32'h99887766);
    do_write(0, 16'h1234, 32'hAABBCCDD);
    do_read(0, 16'h1234, 32'hAABBCCDD);
    do_read(0, 16'h1236, 32'hCCDDAABB);
    do_read(0, 16'h1238, 32'h99887766);

    // Write strobe during a busy read is dropped.
    start(0, 1'b1, 16'h1234);
    @(negedge clk);
    stb[0] = 1'b0;
    @(negedge clk);
    stb[0] = 1'b1; rw_s[0] = 1'b0; ad[0] = 16'h1234; wd[0] = 8'hFF;
    @(negedge clk);
    stb[0] = 1'b0;
    wait_done(0, 3);
    repeat (3) @(negedge clk);
    check("drop_idle", 0, 8'(o_busy[0]), 8'h00);
    do_read(0, 16'h1234, 32'hAABBCCDD);

    // Async reset in cycle 4 of a read.
    start(0, 1'b1, 16'h1234);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      stb[0] = 1'b0;
    end
    check("pre_rst_valid", 0, 8'(o_valid[0]), 8'h01);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 0, 8'(o_valid[0]), 8'h00);
    check("arst_rd", 0, o_rd[0], 8'h00);
    check("arst_busy", 0, 8'(o_busy[0]), 8'h00);
    check("arst_done", 0, 8'(o_done[0]), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    do_read(0, 16'h1234, 32'hAABBCCDD);

    // Zero-latency instance: strobe in the sysdone cycle ignored, next cycle accepted.
    do_write(1, 16'h1234, 32'h01020304);
    do_read(1, 16'h1234, 32'h01020304);
    stb[1] = 1'b1; rw_s[1] = 1'b0; ad[1] = 16'h1234; wd[1] = 8'hEE;
    @(negedge clk);
    check("l0_idle_after_done", 1, 8'(o_busy[1]), 8'h00);
    rw_s[1] = 1'b1;
    @(negedge clk);
    stb[1] = 1'b0;
    check("l0_accept_valid", 1, 8'(o_valid[1]), 8'h01);
    check("l0_accept_rd", 1, o_rd[1], 8'h01);
    wait_done(1, 3);

    // Bottom and top words of the address space.
    do_write(0, 16'h0000, 32'h10203040);
    do_write(0, 16'hFFFC, 32'h50607080);
    do_read(0, 16'h0000, 32'h10203040);
    do_read(0, 16'hFFFC, 32'h50607080);
    do_read(0, 16'hFFFE, 32'h70805060);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
